pixel_lane_scheduler: RTL and testbench
=======================================

PIXEL_LANE_SCHEDULER -- requirements
Module: pixel_lane_scheduler

Interface
REQ-001 The block SHALL have parameter N_LANES, default 4, giving the number of depth-calculator lanes (legal range 1..8).
REQ-002 The block SHALL have parameter X_SIZE, default 640, giving the pixels per line.
REQ-003 The block SHALL have parameter Y_SIZE, default 480, giving the lines per frame.
REQ-004 The block SHALL have parameter DEPTH_W, default 8, giving the depth result width.
REQ-005 The block SHALL have parameter XW, default 10, giving the x coordinate width.
REQ-006 The block SHALL have parameter YW, default 9, giving the y coordinate width.
REQ-007 The block SHALL have port out_stream_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port enable, input, 1 bit: permits issue of new pixels.
REQ-010 The block SHALL have port lane_start, output, N_LANES bits: one-cycle start pulse per lane.
REQ-011 The block SHALL have port lane_x, output, N_LANES*XW bits: per-lane latched x, where lane i occupies bits [i*XW +: XW].
REQ-012 The block SHALL have port lane_y, output, N_LANES*YW bits: per-lane latched y, packed the same way.
REQ-013 The block SHALL have port lane_done, input, N_LANES bits: one-cycle completion pulse per lane.
REQ-014 The block SHALL have port lane_depth, input, N_LANES*DEPTH_W bits: per-lane result, valid while that lane's lane_done is high.
REQ-015 The block SHALL have port pix_depth, output, DEPTH_W bits: in-order result.
REQ-016 The block SHALL have port pix_x, output, XW bits, and port pix_y, output, YW bits: the coordinates of the current pix_depth.
REQ-017 The block SHALL have port pix_valid, output, 1 bit, and port pix_ready, input, 1 bit: the output handshake.
REQ-018 The block SHALL have port pix_sof, output, 1 bit: high when pix_x=0 and pix_y=0; and port pix_eol, output, 1 bit: high when pix_x=X_SIZE-1.
REQ-019 The block SHALL have port frame_count, output, 16 bits: the number of completed frames.
REQ-020 The block SHALL have port proto_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-021 Each lane SHALL run a 3-state FSM: IDLE -> BUSY on its start pulse; BUSY -> HELD on lane_done, capturing lane_depth; HELD -> IDLE on output handshake.
REQ-022 Issue SHALL be round-robin: the issue pointer iss_lane starts at 0 and advances modulo N_LANES, with issue coordinates (iss_x, iss_y) in raster order.
REQ-023 When enable=1 and lane[iss_lane] is IDLE, the block SHALL pulse lane_start[iss_lane] for 1 cycle, latch iss_x/iss_y into that lane's lane_x/lane_y in the same edge, and advance both the pointer and the coordinates.
REQ-024 iss_x SHALL wrap from X_SIZE-1 to 0 and increment iss_y; iss_y SHALL wrap from Y_SIZE-1 to 0; issue continues into the next frame without a gap.
REQ-025 Output SHALL be drained in raster order: pointer out_lane with coordinates (out_x, out_y) advances exactly as the issue pointer does, and pix_valid equals (lane[out_lane]==HELD).
REQ-026 pix_depth, pix_x and pix_y SHALL be driven combinationally from the out_lane captured result and out_x/out_y, and SHALL remain stable while pix_valid=1 and pix_ready=0.
REQ-027 On pix_valid & pix_ready, the lane SHALL return to IDLE and out_lane/out_x/out_y SHALL advance; a lane freed this way SHALL NOT be reissued in the same cycle, so the earliest reissue is the next cycle.
REQ-028 Deasserting enable SHALL stop new issues only; lanes already in BUSY or HELD SHALL complete and drain normally, and reasserting enable SHALL resume issue at the next unissued coordinate.
REQ-029 A lane_done pulse on a lane not in BUSY SHALL be ignored (no capture, no state change) and SHALL set proto_err.
REQ-030 Throughput SHALL be at most one issue and one output per cycle; with N_LANES lanes of latency L, steady-state throughput is min(1, N_LANES/(L+2)) pixels per cycle.
REQ-031 Simultaneous lane_done on multiple lanes SHALL all be captured in the same cycle.

Reset
REQ-032 When reset asserts, the block SHALL asynchronously clear all lanes to IDLE, iss_lane, out_lane, iss_x, iss_y, out_x, out_y, frame_count and proto_err to 0, set lane_start and pix_valid to 0, and clear lane_x/lane_y to 0.
REQ-033 A reset mid-frame SHALL discard all in-flight results, and the first pixel after release SHALL be (0,0) with pix_sof=1.

Configuration
REQ-034 With macro PIXGEN_FRAME_CNT_EN defined, frame_count SHALL increment, wrapping at 16 bits, on the handshake of pixel (X_SIZE-1, Y_SIZE-1); without it, frame_count SHALL be tied to 0 and the counter SHALL not be synthesised.

Verification
REQ-035 N_LANES=4, X_SIZE=8, Y_SIZE=2, lanes return done after 5 cycles with depth=x+8y, pix_ready=1 -> 16 outputs with depth 0..15 in order, pix_sof only on the first, pix_eol on outputs 7 and 15.
REQ-036 Lane latencies 9, 2, 5, 1 cycles (out of order) -> outputs are still in raster order and no lane is reissued before it drains.
REQ-037 pix_ready=0 for 20 cycles mid-frame -> pix_depth/pix_x/pix_y stay stable, all 4 lanes reach HELD, lane_start stays 0, and flow resumes with no loss or duplication when pix_ready=1.
REQ-038 enable dropped after 3 issues -> exactly 3 outputs appear; re-enable -> the next issued coordinate is x=3.
REQ-039 Spurious lane_done[2] while lane 2 is IDLE -> proto_err=1, output sequence unaffected; reset applied mid-frame -> all outputs return to reset values and the next output is (0,0) with pix_sof=1.
REQ-040 With PIXGEN_FRAME_CNT_EN, running 3 full frames -> frame_count=3; without it, frame_count=0 throughout.

Source files
------------

// File: rtl/pixel_lane_scheduler.sv
// ---------------------------------------------------------------------------
// pixel_lane_scheduler
//
// Purpose:
//   This block hands raster-ordered pixel coordinates to N_LANES depth
//   calculators in round-robin order. It collects each lane's result, which
//   may finish out of order, and drains the results back in strict raster
//   order through a valid/ready output port.
//
//   Each lane is a three-state machine:
//     IDLE -> BUSY  on its start pulse
//     BUSY -> HELD  on lane_done (lane_depth is captured here)
//     HELD -> IDLE  when the output handshake accepts it
//   The issue pointer and the drain pointer both walk the lanes in the same
//   round-robin order. Results therefore leave in the order they were issued.
//
// Optional feature:
//   PIXGEN_FRAME_CNT_EN - when this macro is defined, frame_count counts
//   completed frames. It steps on the handshake of pixel
//   (X_SIZE-1, Y_SIZE-1) and wraps at 16 bits. When the macro is not
//   defined, frame_count is a constant 0.
//
// Ports:
//   out_stream_aclk  in   single clock, rising edge
//   reset            in   asynchronous active-high reset
//   enable           in   permits issue of new pixels
//   lane_start       out  [N_LANES]          one-cycle start pulse per lane
//   lane_x           out  [N_LANES*XW]       latched x, lane i at [i*XW +: XW]
//   lane_y           out  [N_LANES*YW]       latched y, lane i at [i*YW +: YW]
//   lane_done        in   [N_LANES]          one-cycle completion per lane
//   lane_depth       in   [N_LANES*DEPTH_W]  result, valid with lane_done
//   pix_depth        out  [DEPTH_W]          in-order result
//   pix_x, pix_y     out                     coordinates of pix_depth
//   pix_valid        out                     output valid
//   pix_ready        in                      output ready
//   pix_sof          out                     pix_x==0 && pix_y==0
//   pix_eol          out                     pix_x==X_SIZE-1
//   frame_count      out  [16]               completed frames
//   proto_err        out                     sticky: lane_done on a lane
//                                            that was not BUSY
// ---------------------------------------------------------------------------
module pixel_lane_scheduler #(
  parameter int N_LANES = 4,
  parameter int X_SIZE  = 640,
  parameter int Y_SIZE  = 480,
  parameter int DEPTH_W = 8,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  logic                       out_stream_aclk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [N_LANES-1:0]         lane_start,
  output logic [N_LANES*XW-1:0]      lane_x,
  output logic [N_LANES*YW-1:0]      lane_y,
  input  logic [N_LANES-1:0]         lane_done,
  input  logic [N_LANES*DEPTH_W-1:0] lane_depth,
  output logic [DEPTH_W-1:0]         pix_depth,
  output logic [XW-1:0]              pix_x,
  output logic [YW-1:0]              pix_y,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic [15:0]                frame_count,
  output logic                       proto_err
);

  localparam int             LW        = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(N_LANES - 1);
  localparam logic [XW-1:0]  X_LAST    = XW'(X_SIZE - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_BUSY = 2'd1,
    LANE_HELD = 2'd2
  } lane_state_t;

  // Issue side: pointer plus the next raster coordinate to hand out.
  logic [LW-1:0] iss_lane_reg;
  logic [XW-1:0] iss_x_reg;
  logic [YW-1:0] iss_y_reg;

  // Drain side: pointer plus the raster coordinate expected next.
  logic [LW-1:0] out_lane_reg;
  logic [XW-1:0] out_x_reg;
  logic [YW-1:0] out_y_reg;

  logic          proto_err_reg;

  // Per-lane status, flattened so the pointers can select a lane.
  logic [N_LANES-1:0]         lane_idle;
  logic [N_LANES-1:0]         lane_held;
  logic [N_LANES-1:0]         lane_err;
  logic [N_LANES*DEPTH_W-1:0] depth_flat;

  logic iss_fire;
  logic out_fire;

  // A lane freed by the handshake is still HELD during that cycle. Its idle
  // flag is therefore low, so the lane cannot be reissued before the next
  // cycle.
  assign iss_fire = enable & lane_idle[iss_lane_reg];
  assign out_fire = lane_held[out_lane_reg] & pix_ready;

  // -------------------------------------------------------------------------
  // Lanes
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      lane_state_t         state_reg;
      logic                start_reg;
      logic [XW-1:0]       x_reg;
      logic [YW-1:0]       y_reg;
      logic [DEPTH_W-1:0]  depth_reg;
      logic                start_sel;
      logic                drain_sel;

      assign start_sel = iss_fire && (iss_lane_reg == LW'(gi));
      assign drain_sel = out_fire && (out_lane_reg == LW'(gi));

      always_ff @(posedge out_stream_aclk or posedge reset) begin
        if (reset) begin
          state_reg <= LANE_IDLE;
          start_reg <= 1'b0;
          x_reg     <= '0;
          y_reg     <= '0;
          depth_reg <= '0;
        end else begin
          start_reg <= start_sel;
          case (state_reg)
            LANE_IDLE: begin
              if (start_sel) begin
                state_reg <= LANE_BUSY;
                x_reg     <= iss_x_reg;
                y_reg     <= iss_y_reg;
              end
            end
            LANE_BUSY: begin
              if (lane_done[gi]) begin
                state_reg <= LANE_HELD;
                depth_reg <= lane_depth[gi*DEPTH_W +: DEPTH_W];
              end
            end
            LANE_HELD: begin
              if (drain_sel) begin
                state_reg <= LANE_IDLE;
              end
            end
            default: state_reg <= LANE_IDLE;
          endcase
        end
      end

      assign lane_idle[gi]                        = (state_reg == LANE_IDLE);
      assign lane_held[gi]                        = (state_reg == LANE_HELD);
      // A done pulse outside BUSY is dropped by the FSM above and only
      // flagged here.
      assign lane_err[gi]                         = lane_done[gi] && (state_reg != LANE_BUSY);
      assign lane_start[gi]                       = start_reg;
      assign lane_x[gi*XW +: XW]                  = x_reg;
      assign lane_y[gi*YW +: YW]                  = y_reg;
      assign depth_flat[gi*DEPTH_W +: DEPTH_W]    = depth_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Issue pointer and raster coordinates
  // -------------------------------------------------------------------------
  always_ff @(posedge out_stream_aclk or posedge reset) begin
    if (reset) begin
      iss_lane_reg <= '0;
      iss_x_reg    <= '0;
      iss_y_reg    <= '0;
    end else if (iss_fire) begin
      iss_lane_reg <= (iss_lane_reg == LAST_LANE) ? '0 : iss_lane_reg + 1'b1;
      if (iss_x_reg == X_LAST) begin
        iss_x_reg <= '0;
        iss_y_reg <= (iss_y_reg == Y_LAST) ? '0 : iss_y_reg + 1'b1;
      end else begin
        iss_x_reg <= iss_x_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Drain pointer and raster coordinates (same walk as issue)
  // -------------------------------------------------------------------------
  always_ff @(posedge out_stream_aclk or posedge reset) begin
    if (reset) begin
      out_lane_reg <= '0;
      out_x_reg    <= '0;
      out_y_reg    <= '0;
    end else if (out_fire) begin
      out_lane_reg <= (out_lane_reg == LAST_LANE) ? '0 : out_lane_reg + 1'b1;
      if (out_x_reg == X_LAST) begin
        out_x_reg <= '0;
        out_y_reg <= (out_y_reg == Y_LAST) ? '0 : out_y_reg + 1'b1;
      end else begin
        out_x_reg <= out_x_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky protocol error
  // -------------------------------------------------------------------------
  always_ff @(posedge out_stream_aclk or posedge reset) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
    end else if (|lane_err) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;

  // -------------------------------------------------------------------------
  // Frame counter
  // -------------------------------------------------------------------------
`ifdef PIXGEN_FRAME_CNT_EN
  logic [15:0] frame_count_reg;

  always_ff @(posedge out_stream_aclk or posedge reset) begin
    if (reset) begin
      frame_count_reg <= '0;
    end else if (out_fire && (out_x_reg == X_LAST) && (out_y_reg == Y_LAST)) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = '0;
`endif

  // -------------------------------------------------------------------------
  // Output port. Everything below is decoded from held state only, so it
  // stays constant while the output is stalled.
  // -------------------------------------------------------------------------
  assign pix_valid = lane_held[out_lane_reg];
  assign pix_depth = depth_flat[out_lane_reg*DEPTH_W +: DEPTH_W];
  assign pix_x     = out_x_reg;
  assign pix_y     = out_y_reg;
  assign pix_sof   = (out_x_reg == '0) && (out_y_reg == '0);
  assign pix_eol   = (out_x_reg == X_LAST);

endmodule

// File: tb/tb_pixel_lane_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pixel_lane_scheduler
//
// Randomised bench for pixel_lane_scheduler: N_LANES=4, 8x2 frame.
//
// Each lane is emulated as a calculator with a programmable latency. The
// reference model keeps a queue of in-flight pixels in issue order. It
// predicts the following from that queue:
//   - which lane must start next, and with what coordinates;
//   - when the output is valid, and what it carries;
//   - the expected protocol-error state;
//   - the expected frame count.
// ---------------------------------------------------------------------------
module tb_pixel_lane_scheduler;

  localparam int N  = 4;
  localparam int XS = 8;
  localparam int YS = 2;
  localparam int DW = 8;
  localparam int XW = 10;
  localparam int YW = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [N-1:0]      lane_start;
  logic [N*XW-1:0]   lane_x;
  logic [N*YW-1:0]   lane_y;
  logic [N-1:0]      lane_done;
  logic [N*DW-1:0]   lane_depth;
  logic [DW-1:0]     pix_depth;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic [15:0]       frame_count;
  logic              proto_err;

  always #5 clk = ~clk;

  pixel_lane_scheduler #(
    .N_LANES (N),
    .X_SIZE  (XS),
    .Y_SIZE  (YS),
    .DEPTH_W (DW),
    .XW      (XW),
    .YW      (YW)
  ) dut (
    .out_stream_aclk (clk),
    .reset           (reset),
    .enable          (enable),
    .lane_start      (lane_start),
    .lane_x          (lane_x),
    .lane_y          (lane_y),
    .lane_done       (lane_done),
    .lane_depth      (lane_depth),
    .pix_depth       (pix_depth),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol),
    .frame_count     (frame_count),
    .proto_err       (proto_err)
  );

  typedef struct {
    int lane;
    int x;
    int y;
    int depth;
    int cnt;
    bit done;
  } rec_t;

  rec_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int il, ix, iy;
  bit exp_issue;
  bit exp_perr;
  int exp_frames;
  int issue_limit;
  int issue_planned;
  int hs_seen;

  // Stimulus knobs
  int lat_mode;
  int lat_tab[N];
  int ready_pct;
  int enable_pct;
  int salt;
  bit want_x3;
  bit want_sof;
  bit inject_spur;

`ifdef PIXGEN_FRAME_CNT_EN
  localparam int FRAMES_EXP = 3;
`else
  localparam int FRAMES_EXP = 0;
`endif

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit lane_in_flight(input int lane);
    for (int i = 0; i < q.size(); i++)
      if (q[i].lane == lane) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_lat(input int lane);
    if (lat_mode == 0) return lat_tab[lane];
    return int'($urandom_range(12, 1));
  endfunction

  // One clock cycle. Observe what the previous edge produced, then drive the
  // inputs for the coming edge and predict its effect.
  task automatic step();
    logic [N-1:0]    exp_start;
    logic [N-1:0]    done_v;
    logic [N*DW-1:0] depth_v;
    bit              exp_valid;
    bit              hs;
    rec_t            r;

    @(negedge clk);

    exp_start = '0;
    if (exp_issue) exp_start[il] = 1'b1;
    check_eq("lane_start", lane_start, exp_start);
    if (exp_issue) begin
      check_eq("lane_xy", {lane_x[il*XW +: XW], lane_y[il*YW +: YW]}, {XW'(ix), YW'(iy)});
      if (want_x3) begin
        check_eq("reissue_x", lane_x[il*XW +: XW], 3);
        want_x3 = 1'b0;
      end
      r.lane  = il;
      r.x     = ix;
      r.y     = iy;
      r.depth = (ix + XS * iy + salt) & 255;
      r.cnt   = pick_lat(il);
      r.done  = 1'b0;
      q.push_back(r);
      il = (il + 1) % N;
      ix++;
      if (ix == XS) begin
        ix = 0;
        iy = (iy + 1) % YS;
      end
    end

    exp_valid = (q.size() > 0) && q[0].done;
    check_eq("pix_valid", pix_valid, exp_valid);
    if (exp_valid)
      check_eq("pix_data", {pix_x, pix_y, pix_depth},
               {XW'(q[0].x), YW'(q[0].y), DW'(q[0].depth)});
    check_eq("proto_err", proto_err, exp_perr);
    check_eq("frame_count", frame_count, exp_frames);

    // Drive inputs for the coming edge.
    enable    = ((issue_limit < 0) || (issue_planned < issue_limit)) &&
                ($urandom_range(99) < enable_pct);
    pix_ready = ($urandom_range(99) < ready_pct);
    done_v    = '0;
    for (int i = 0; i < N; i++) depth_v[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      r = q[i];
      if (!r.done) begin
        r.cnt--;
        if (r.cnt <= 0) begin
          r.done = 1'b1;
          done_v[r.lane] = 1'b1;
          depth_v[r.lane*DW +: DW] = DW'(r.depth);
        end
        q[i] = r;
      end
    end
    if (inject_spur) begin
      done_v[2]   = 1'b1;
      exp_perr    = 1'b1;
      inject_spur = 1'b0;
    end
    lane_done  = done_v;
    lane_depth = depth_v;

    hs = exp_valid && pix_ready;
    if (pix_valid && pix_ready) hs_seen++;
    if (hs) begin
      check_eq("pix_sof_eol", {pix_sof, pix_eol},
               {(q[0].x == 0) && (q[0].y == 0), q[0].x == XS - 1});
      if (want_sof) begin
        check_eq("sof_after_reset", {pix_sof, pix_x, pix_y}, {1'b1, XW'(0), YW'(0)});
        want_sof = 1'b0;
      end
`ifdef PIXGEN_FRAME_CNT_EN
      if ((q[0].x == XS - 1) && (q[0].y == YS - 1)) exp_frames = (exp_frames + 1) & 16'hFFFF;
`endif
    end

    // A lane being drained at this edge still counts as occupied.
    exp_issue = enable && !lane_in_flight(il);
    if (exp_issue) issue_planned++;
    if (hs) q.delete(0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    enable    = 1'b0;
    pix_ready = 1'b0;
    lane_done = '0;
    #1;
    // No clock edge has occurred yet, so these values come from the
    // asynchronous clear.
    check_eq("rst_pix_valid", pix_valid, 0);
    check_eq("rst_lane_start", lane_start, 0);
    check_eq("rst_lane_xy", {lane_x, lane_y}, 0);
    check_eq("rst_status", {proto_err, frame_count}, 0);
    check_eq("rst_pix_xy", {pix_x, pix_y}, 0);
    q.delete();
    il = 0; ix = 0; iy = 0;
    exp_issue = 1'b0; exp_perr = 1'b0; exp_frames = 0;
    issue_planned = 0; hs_seen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_drained(input int limit, input int budget);
    issue_limit = limit;
    while ((budget > 0) &&
           !((issue_planned >= issue_limit) && (q.size() == 0) && !exp_issue)) begin
      step();
      budget--;
    end
    check_eq("drain_pending", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    lane_done = '0; lane_depth = '0;
    issue_limit = -1; inject_spur = 1'b0; want_x3 = 1'b0; want_sof = 1'b0;
    salt = 0; lat_mode = 0; ready_pct = 100; enable_pct = 100;
    for (int i = 0; i < N; i++) lat_tab[i] = 5;

    // One frame with fixed latency 5 and depth = x + 8y.
    do_reset();
    want_sof = 1'b1;
    run_until_drained(16, 300);
    check_eq("frame0_outputs", hs_seen, 16);

    // Lanes finish out of order.
    do_reset();
    lat_tab[0] = 9; lat_tab[1] = 2; lat_tab[2] = 5; lat_tab[3] = 1;
    run_until_drained(40, 600);
    check_eq("ooo_outputs", hs_seen, 40);

    // Output stalled for 20 cycles in mid-frame.
    salt = int'($urandom_range(255));
    for (int i = 0; i < N; i++) lat_tab[i] = 3;
    issue_limit = -1;
    repeat (6) step();
    ready_pct = 0;
    repeat (20) step();
    ready_pct = 100;
    run_until_drained(issue_planned + 12, 400);

    // Enable dropped after 3 issues, then re-enabled.
    do_reset();
    salt = 0;
    run_until_drained(3, 200);
    check_eq("three_outputs", hs_seen, 3);
    want_x3 = 1'b1;
    run_until_drained(10, 300);

    // Spurious done on idle lane 2.
    inject_spur = 1'b1;
    step();
    step();
    check_eq("proto_err_set", proto_err, 1);
    lat_mode = 1; ready_pct = 70;
    run_until_drained(issue_planned + 20, 600);

    // Reset in mid-frame, followed by long random traffic.
    issue_limit = -1; enable_pct = 90;
    repeat (13) step();
    do_reset();
    want_sof = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      salt = (k / 300) * 17;
      step();
      if (k == 700) begin
        do_reset();
        want_sof = 1'b1;
      end
    end
    run_until_drained(issue_planned, 600);

    // Three full frames.
    do_reset();
    ready_pct = 100; enable_pct = 100;
    run_until_drained(3 * XS * YS, 1500);
    step();
    check_eq("frame_count_3", frame_count, FRAMES_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
